serial_adder_sf: RTL and testbench

Bit-serial adder that inverts the full-subtractor datapath. It takes a difference word D, a subtrahend word B and a borrow-in, and reconstructs the minuend A = D + B + cin one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It sits beside the full-subtractor blocks in the adders/subtractors library as their round-trip checker and reverse-direction datapath. A start/busy/done handshake frames each word.

---
 rtl/serial_adder_sf.sv | 119 +++++++++++
 tb/tb_serial_adder_sf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sf.sv
// Bit-serial adder: rebuilds A = D + B + cin one bit per clock, LSB first,
// through a single full-adder cell and a carry flip-flop; start/busy/done framed.
module serial_adder_sf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_next;

    // The one full-adder cell shared by every bit position.
    always_comb begin
        sum_bit    = dr_q[0] ^ br_q[0] ^ c_q;
        carry_next = (dr_q[0] & br_q[0]) | (c_q & (dr_q[0] ^ br_q[0]));
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        dr_d    = dr_q;
        br_d    = br_q;
        ar_d    = ar_q;
        a_out_d = a_out_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dr_d    = d_in;
                    br_d    = b_in;
                    c_d     = cin;
                    ar_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ar_d  = {sum_bit, ar_q[WIDTH-1:1]};
                dr_d  = dr_q >> 1;
                br_d  = br_q >> 1;
                c_d   = carry_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    a_out_d = {sum_bit, ar_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            dr_q    <= '0;
            br_q    <= '0;
            ar_q    <= '0;
            a_out_q <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            br_q    <= br_d;
            ar_q    <= ar_d;
            a_out_q <= a_out_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign a_out = a_out_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_sf.sv
// Self-checking bench for serial_adder_sf: table-driven vectors, handshake and
// reset corner sequences at WIDTH=8, and a full-subtractor round trip at WIDTH=4.
module tb_serial_adder_sf;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] d8, b8, a_out8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] d4, b4, a_out4;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb8[$];
    logic [4:0] sb4[$];

    typedef struct {
        logic [7:0] d;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_a;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_adder_sf #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .d_in  (d8),
        .b_in  (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .a_out (a_out8),
        .cout  (cout8)
    );

    serial_adder_sf #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .d_in  (d4),
        .b_in  (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .a_out (a_out4),
        .cout  (cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: results are compared whenever a done pulse is seen.
    always @(negedge clk) begin
        logic [8:0] e8;
        logic [4:0] e4;
        if (done8) begin
            if (sb8.size() == 0) begin
                check("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                e8 = sb8.pop_front();
                check("a_out8", 32'(a_out8), 32'(e8[7:0]));
                check("cout8", 32'(cout8), 32'(e8[8]));
            end
        end
        if (done4) begin
            if (sb4.size() == 0) begin
                check("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e4 = sb4.pop_front();
                check("a_out4", 32'(a_out4), 32'(e4[3:0]));
                check("cout4", 32'(cout4), 32'(e4[4]));
            end
        end
    end

    // Ripple full subtractor: returns {bout, D} for A - B - bin.
    function automatic logic [4:0] fullsub4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [3:0] d;
        logic       bw;
        bw = bin;
        for (int i = 0; i < 4; i++) begin
            d[i] = a[i] ^ b[i] ^ bw;
            bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        return {bw, d};
    endfunction

    task automatic run8(input logic [7:0] d, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, output int lat, output int bcyc);
        @(posedge clk); #1;
        start8 = 1'b1; d8 = d; b8 = b; cin8 = c;
        sb8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        d8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat  = -1;
        bcyc = 0;
        for (int j = 0; j <= 24; j++) begin
            if (busy8) bcyc++;
            if (done8 && lat < 0) lat = j;
            if (!busy8) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic run4(input logic [3:0] d, input logic [3:0] b, input logic c, input logic [4:0] exp);
        @(posedge clk); #1;
        start4 = 1'b1; d4 = d; b4 = b; cin4 = c;
        sb4.push_back(exp);
        @(posedge clk); #1;
        start4 = 1'b0;
        d4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        for (int j = 0; j < 16 && busy4; j++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat, bcyc;
        logic active;

        vecs[0] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'hC3, 8'h1E, 1'b0, 8'hE1, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; d8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; d4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset and idle behaviour.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_a_out", 32'(a_out8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        active = 1'b0;
        d8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy8 || done8 || a_out8 != 8'h00 || cout8) active = 1'b1;
        end
        check("idle_quiet", 32'(active), 32'd0);

        // Vector table: value via scoreboard, timing checked here.
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].d, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_a}, lat, bcyc);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'd9);
        end
        check("hold_a_out", 32'(a_out8), 32'hE1);

        // Handshake: starts during SHIFT and DONE are ignored, held start accepted at E10.
        @(posedge clk); #1;
        start8 = 1'b1; d8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        sb8.push_back({1'b0, 8'h30});
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) begin
                start8 = 1'b1; d8 = 8'hAA;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("hs_done_at_E8", 32'(done8), 32'd1);
        start8 = 1'b1; d8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        @(posedge clk); #1;
        check("hs_idle_after_E9", 32'(busy8), 32'd0);
        d8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
        sb8.push_back({1'b0, 8'h04});
        @(posedge clk); #1;
        check("hs_accept_E10", 32'(busy8), 32'd1);
        start8 = 1'b0;
        for (int j = 0; j < 20 && busy8; j++) begin
            @(posedge clk); #1;
        end
        check("hs_second_idle", 32'(busy8), 32'd0);
        check("hs_second_a_out", 32'(a_out8), 32'h04);

        // Reset mid-operation aborts with no done pulse and clears outputs.
        @(posedge clk); #1;
        start8 = 1'b1; d8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_a_out", 32'(a_out8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy8), 32'd0);
        run8(8'h01, 8'h01, 1'b0, {1'b0, 8'h02}, lat, bcyc);
        check("post_abort_latency", 32'(lat), 32'd8);

        // Round trip against the full subtractor at WIDTH=4.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    logic [4:0] fs;
                    fs = fullsub4(4'(a), 4'(b), 1'(bin));
                    run4(fs[3:0], 4'(b), 1'(bin), {fs[4], 4'(a)});
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb8_drained", 32'(sb8.size()), 32'd0);
        check("sb4_drained", 32'(sb4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
